// File: rtl/jtag_scan_master.sv
// JTAG scan master: divides CK into TCLK, walks the TAP from Run-Test/Idle
// through an IR or DR scan of 1..256 bits and back, capturing TDO into data_out.
// TMS/TDI only move on TCLK falling edges. TDO is sampled on TCLK rising edges.
module jtag_scan_master #(
  parameter int unsigned DIV_HALF = 5
) (
  input  logic         CK,
  input  logic         TRST,
  input  logic         start,
  input  logic         is_ir,
  input  logic [8:0]   len,
  input  logic [255:0] data_in,
  input  logic         TDO,
  output logic         TCLK,
  output logic         TMS,
  output logic         TDI,
  output logic         busy,
  output logic         done,
  output logic [255:0] data_out
);

  // Each state is named after the TAP state the target sits in while the
  // controller presents TMS/TDI for the next TCLK rising edge.
  typedef enum logic [3:0] {
    StInit, StIdle, StRti, StSelDr, StSelIr, StCapture, StShift, StExit1, StUpdate
  } state_e;

  localparam logic [7:0] CntMax = 8'(DIV_HALF - 1);

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         tclk_q, tclk_d;
  logic         tms_q, tms_d;
  logic         tdi_q, tdi_d;
  logic         done_q, done_d;
  logic [2:0]   init_cnt_q, init_cnt_d;
  logic [8:0]   bit_q, bit_d;
  logic [8:0]   len_q, len_d;
  logic         ir_q, ir_d;
  logic [255:0] shreg_q, shreg_d;
  logic [255:0] data_out_q, data_out_d;

  logic tick;
  logic rise;
  logic fall;

  assign busy     = (state_q != StIdle);
  assign tick     = busy && (cnt_q == CntMax);
  assign rise     = tick && !tclk_q;
  assign fall     = tick && tclk_q;
  assign TCLK     = tclk_q;
  assign TMS      = tms_q;
  assign TDI      = tdi_q;
  assign done     = done_q;
  assign data_out = data_out_q;

  // State register with asynchronous active-low reset into INIT
  always_ff @(posedge CK or negedge TRST) begin
    if (!TRST) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      tclk_q     <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      done_q     <= 1'b0;
      init_cnt_q <= '0;
      bit_q      <= '0;
      len_q      <= '0;
      ir_q       <= 1'b0;
      shreg_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tclk_q     <= tclk_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      done_q     <= done_d;
      init_cnt_q <= init_cnt_d;
      bit_q      <= bit_d;
      len_q      <= len_d;
      ir_q       <= ir_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
    end
  end

  // Clock divider, TDO capture and TAP sequencing; transitions happen on TCLK falls
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tclk_d     = tclk_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    done_d     = 1'b0;
    init_cnt_d = init_cnt_q;
    bit_d      = bit_q;
    len_d      = len_q;
    ir_d       = ir_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;

    if (busy) begin
      if (tick) begin
        cnt_d  = '0;
        tclk_d = !tclk_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (rise) begin
      if (state_q == StInit) init_cnt_d = init_cnt_q + 3'd1;
      if (state_q == StShift) data_out_d[bit_q[7:0]] = TDO;
    end

    case (state_q)
      StInit: begin
        if (fall) begin
          if (init_cnt_q == 3'd5) begin
            tms_d = 1'b0;
          end else if (init_cnt_q == 3'd6) begin
            // Park TMS high so the next scan needs no change before its first edge
            state_d = StIdle;
            tms_d   = 1'b1;
          end
        end
      end
      StIdle: begin
        // A start in the done cycle is dropped so scans never chain back to back
        if (start && !done_q && (len != 9'd0) && (len <= 9'd256)) begin
          state_d    = StRti;
          ir_d       = is_ir;
          len_d      = len;
          shreg_d    = data_in;
          data_out_d = '0;
          cnt_d      = '0;
          tclk_d     = 1'b0;
        end
      end
      StRti: begin
        if (fall) begin
          state_d = StSelDr;
          tms_d   = ir_q;
        end
      end
      StSelDr: begin
        if (fall) begin
          state_d = ir_q ? StSelIr : StCapture;
          tms_d   = 1'b0;
        end
      end
      StSelIr: begin
        if (fall) begin
          state_d = StCapture;
          tms_d   = 1'b0;
        end
      end
      StCapture: begin
        if (fall) begin
          state_d = StShift;
          bit_d   = '0;
          tdi_d   = shreg_q[0];
          tms_d   = (len_q == 9'd1);
        end
      end
      StShift: begin
        if (fall) begin
          if (bit_q == len_q - 9'd1) begin
            state_d = StExit1;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_d   = bit_q + 9'd1;
            shreg_d = shreg_q >> 1;
            tdi_d   = shreg_q[1];
            tms_d   = (bit_q + 9'd2 == len_q);
          end
        end
      end
      StExit1: begin
        if (fall) begin
          state_d = StUpdate;
          tms_d   = 1'b0;
        end
      end
      StUpdate: begin
        if (fall) begin
          state_d = StIdle;
          tms_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL have parameter DIV_HALF, default 5, giving the number of CK cycles per TCLK half-period (legal range 1..255).
REQ-002 SHALL have port CK, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port TRST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-CK request pulse, sampled only while busy=0.
REQ-005 SHALL have port is_ir, input, 1 bit: 1 selects an IR scan, 0 selects a DR scan; captured together with start.
REQ-006 SHALL have port len, input, 9 bits: scan length in bits; legal values 1..256; captured with start.
REQ-007 SHALL have port data_in, input, 256 bits: shift vector, sent LSB first; captured with start.
REQ-008 SHALL have port TDO, input, 1 bit: serial data returned by the target TAP.
REQ-009 SHALL have port TCLK, output, 1 bit: the generated test clock.
REQ-010 SHALL have port TMS, output, 1 bit: the test mode select.
REQ-011 SHALL have port TDI, output, 1 bit: the test data in.
REQ-012 SHALL have port busy, output, 1 bit: high while the init sequence or a scan is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-CK pulse when a scan completes.
REQ-014 SHALL have port data_out, output, 256 bits: captured TDO bits; bit i holds the i-th shifted bit.

Function
REQ-015 TCLK SHALL toggle every DIV_HALF CK cycles whenever busy=1, and SHALL be held at 0 while busy=0.
REQ-016 TMS and TDI SHALL change only on the CK edge at which TCLK goes 1->0.
REQ-017 TDO SHALL be sampled only on the CK edge at which TCLK goes 0->1.
REQ-018 The controller SHALL implement the states INIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI.
REQ-019 In INIT, the block SHALL drive TMS=1 for 5 TCLK rising edges, then TMS=0 for 1 rising edge (Test-Logic-Reset to Run-Test/Idle), then go to IDLE with busy=0.
REQ-020 In IDLE, start=1 with len in 1..256 SHALL latch is_ir, len and data_in, set busy=1 on the next CK edge, and clear data_out to 0.
REQ-021 In IDLE, start=1 with len=0 or len>256 SHALL be ignored: busy stays 0 and done is not pulsed.
REQ-022 The TMS sequence for a DR scan SHALL be 1 (SEL_DR), 0 (CAPTURE), 0 (into SHIFT).
REQ-023 The TMS sequence for an IR scan SHALL be 1, 1 (SEL_IR), 0 (CAPTURE), 0 (into SHIFT).
REQ-024 In SHIFT, the block SHALL present TDI=data_in[k] for k=0..len-1, one bit per TCLK period.
REQ-025 In SHIFT, TMS SHALL be 0 for bits 0..len-2 and 1 for bit len-1, which moves the TAP to EXIT1.
REQ-026 The TDO value sampled on the rising edge that clocks TDI bit k SHALL be stored in data_out[k]; data_out bits len..255 SHALL remain 0.
REQ-027 After EXIT1, the block SHALL drive TMS=1 for UPDATE and then TMS=0 for RTI; after the RTI rising edge it SHALL return to IDLE.
REQ-028 On the return to IDLE, busy SHALL fall and done SHALL pulse for exactly one CK cycle, in the same CK cycle.
REQ-029 With len=1, the single shifted bit SHALL carry TMS=1; no TMS=0 SHALL occur in SHIFT.
REQ-030 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-031 start asserted in the same cycle as done SHALL be ignored.
REQ-032 TDI SHALL be 0 in every state other than SHIFT.
REQ-033 The half-period counter SHALL restart at 0 when a scan begins, so the first TCLK rising edge occurs exactly DIV_HALF CK cycles after busy rises.

Reset
REQ-034 While TRST=0, the outputs SHALL be TCLK=0, TMS=1, TDI=0, busy=1, done=0, data_out=0, and the state SHALL be INIT.
REQ-035 Assertion of TRST SHALL take effect immediately, including mid-scan, and SHALL abort the scan with no done pulse.
REQ-036 After TRST deasserts, the block SHALL re-run INIT before it accepts any start.

Verification
REQ-037 Reset then release -> TMS=1 on 5 rising TCLK edges, TMS=0 on 1 rising edge, busy falls after that; TDI=0 throughout.
REQ-038 IR scan, len=2, data_in=2'b11 -> TMS at rising edges 1,1,0,0,0,1,1,0; TDI=1 on the two shift edges; done=1 for 1 CK.
REQ-039 DR scan, len=36, data_in=36'h0, with a TAP model returning its BSR -> data_out[35:0] equals the model capture value; busy high for exactly (3+36+2)*2*DIV_HALF CK cycles.
REQ-040 DR scan, len=211, data_in=211'hdeadbeef, loop TDI->TDO through a 211-bit shift register preloaded to 0 -> data_out=0; a second identical scan -> data_out[210:0]=211'hdeadbeef.
REQ-041 len=1, DR, data_in[0]=1, TDO tied to 1 -> TMS=1 on the single shift edge; data_out=256'h1.
REQ-042 Drive TRST low during SHIFT bit 50 of a len=100 scan -> outputs return to reset values at once with no done pulse; after release, INIT is replayed; start with len=0 -> busy stays 0 and no done pulse.
